// File: rtl/soc_wrap_core.sv
// Debug monitor: 8N1 UART command parser (poke/peek) over a 16x8 register file that also
// drives an 8-bit bidirectional GPIO port. Boot banner is sent after every debug reset.
module soc_wrap_core #(
   parameter int unsigned CLK_FREQ_MHZ      = 50,
   parameter int unsigned DEBUG_SERIAL_BAUD = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       db_resetn,
   input  logic       test_enable,
   input  logic       db_rxd,
   output logic       db_txd,
   inout  wire  [7:0] gpio_port_a
);
   localparam int unsigned BIT  = CLK_FREQ_MHZ * 1000000 / DEBUG_SERIAL_BAUD;
   localparam int unsigned HALF = BIT / 2;
   localparam int unsigned CW   = $clog2(BIT + 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_IDLE, P_SP1, P_ADDR, P_SP2, P_DHI, P_DLO, P_EOL} p_state_t;
   typedef enum logic {T_IDLE, T_SEND} tx_state_t;

   function automatic logic [4:0] hex_val(input logic [7:0] c);
      if (c >= "0" && c <= "9") return {1'b1, 4'(c - 8'h30)};
      if (c >= "A" && c <= "F") return {1'b1, 4'(c - 8'h37)};
      if (c >= "a" && c <= "f") return {1'b1, 4'(c - 8'h57)};
      return 5'b0;
   endfunction

   function automatic logic [7:0] hex_chr(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] banner_chr(input logic [3:0] i);
      case (i)
         4'd0, 4'd3: return "D";
         4'd1:       return "W";
         4'd2:       return "_";
         4'd4, 4'd9: return "e";
         4'd5:       return "b";
         4'd6:       return "u";
         4'd7, 4'd8: return "g";
         4'd10:      return "r";
         4'd11:      return 8'h0D;
         4'd12:      return 8'h0A;
         default:    return 8'h00;
      endcase
   endfunction

   // Reset synchronizers: asynchronous assert, two-flop synchronous release
   logic core_meta, core_rst_n, db_meta, db_rst_n;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin core_meta <= 1'b0; core_rst_n <= 1'b0; end
      else         begin core_meta <= 1'b1; core_rst_n <= core_meta; end
   end
   always_ff @(posedge clk or negedge db_resetn) begin
      if (!db_resetn) begin db_meta <= 1'b0; db_rst_n <= 1'b0; end
      else            begin db_meta <= 1'b1; db_rst_n <= db_meta; end
   end

   logic [2:0] rxd_q;
   logic [7:0] pin_q1, pin_s;
   logic       rx_s, rx_prev;
   assign rx_s    = rxd_q[1];
   assign rx_prev = rxd_q[2];

   rx_state_t     rx_st, rx_st_nx;
   logic [CW-1:0] rx_cnt, rx_cnt_nx;
   logic [2:0]    rx_bit, rx_bit_nx;
   logic [7:0]    rx_sh, rx_sh_nx;
   logic          rx_vld, rx_vld_nx;

   p_state_t   p_st, p_st_nx;
   logic       p_wr, p_wr_nx;
   logic [3:0] p_addr, p_addr_nx;
   logic [7:0] p_data, p_data_nx;
   logic [4:0] hex_c;
   logic       err_c, req_c, we_c;
   logic [2:0] req_len_c;
   logic [31:0] req_msg_c;
   logic [7:0] rd_c;
   logic [7:0] regs [16];

   logic          banner_pend, banner_pend_nx, msg_act, msg_act_nx, msg_ban, msg_ban_nx;
   logic [3:0]    msg_idx, msg_idx_nx, msg_len, msg_len_nx;
   logic [31:0]   msg_buf, msg_buf_nx;
   tx_state_t     tx_st, tx_st_nx;
   logic [9:0]    tx_sh, tx_sh_nx;
   logic [CW-1:0] tx_cnt, tx_cnt_nx;
   logic [3:0]    tx_bit, tx_bit_nx;

   // Debug-domain state registers
   always_ff @(posedge clk or negedge db_rst_n) begin
      if (!db_rst_n) begin
         rxd_q <= 3'b111; pin_q1 <= '0; pin_s <= '0;
         rx_st <= R_IDLE; rx_cnt <= '0; rx_bit <= '0; rx_sh <= '0; rx_vld <= 1'b0;
         p_st <= P_IDLE; p_wr <= 1'b0; p_addr <= '0; p_data <= '0;
         banner_pend <= 1'b1; msg_act <= 1'b0; msg_ban <= 1'b0;
         msg_idx <= '0; msg_len <= '0; msg_buf <= '0;
         tx_st <= T_IDLE; tx_sh <= '1; tx_cnt <= '0; tx_bit <= '0;
         db_txd <= 1'b1;
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else begin
         rxd_q <= {rxd_q[1:0], db_rxd}; pin_q1 <= gpio_port_a; pin_s <= pin_q1;
         rx_st <= rx_st_nx; rx_cnt <= rx_cnt_nx; rx_bit <= rx_bit_nx;
         rx_sh <= rx_sh_nx; rx_vld <= rx_vld_nx;
         p_st <= p_st_nx; p_wr <= p_wr_nx; p_addr <= p_addr_nx; p_data <= p_data_nx;
         banner_pend <= banner_pend_nx; msg_act <= msg_act_nx; msg_ban <= msg_ban_nx;
         msg_idx <= msg_idx_nx; msg_len <= msg_len_nx; msg_buf <= msg_buf_nx;
         tx_st <= tx_st_nx; tx_sh <= tx_sh_nx; tx_cnt <= tx_cnt_nx; tx_bit <= tx_bit_nx;
         db_txd <= test_enable ? rx_s : ((tx_st == T_SEND) ? tx_sh[0] : 1'b1);
         if (we_c) regs[p_addr] <= p_data;
      end
   end

   // RX: start confirmed at half bit, then data and stop sampled at bit centres
   always_comb begin
      rx_st_nx = rx_st; rx_cnt_nx = rx_cnt + 1'b1; rx_bit_nx = rx_bit;
      rx_sh_nx = rx_sh; rx_vld_nx = 1'b0;
      case (rx_st)
         R_IDLE: begin
            rx_cnt_nx = '0;
            if (rx_prev && !rx_s) rx_st_nx = R_START;
         end
         R_START: if (rx_cnt == CW'(HALF - 1)) begin
            rx_cnt_nx = '0; rx_bit_nx = '0;
            rx_st_nx  = rx_s ? R_IDLE : R_DATA;
         end
         R_DATA: if (rx_cnt == CW'(BIT - 1)) begin
            rx_cnt_nx = '0; rx_sh_nx = {rx_s, rx_sh[7:1]}; rx_bit_nx = rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_st_nx = R_STOP;
         end
         R_STOP: if (rx_cnt == CW'(BIT - 1)) begin
            rx_st_nx = R_IDLE; rx_vld_nx = rx_s;
         end
         default: rx_st_nx = R_IDLE;
      endcase
   end

   assign rd_c = (p_addr == 4'hD) ? pin_s : regs[p_addr];

   // Command parser; NUL and CR are transparent in every state
   always_comb begin
      p_st_nx = p_st; p_wr_nx = p_wr; p_addr_nx = p_addr; p_data_nx = p_data;
      hex_c = hex_val(rx_sh); err_c = 1'b0; req_c = 1'b0; we_c = 1'b0;
      req_len_c = 3'd3; req_msg_c = {"?\r\n", 8'h00};
      if (rx_vld && !test_enable && rx_sh != 8'h00 && rx_sh != 8'h0D) begin
         case (p_st)
            P_IDLE: if (rx_sh == "p" || rx_sh == "r") begin
               p_wr_nx = (rx_sh == "p"); p_st_nx = P_SP1;
            end else err_c = 1'b1;
            P_SP1: if (rx_sh == " ") p_st_nx = P_ADDR; else err_c = 1'b1;
            P_ADDR: if (hex_c[4]) begin
               p_addr_nx = hex_c[3:0]; p_st_nx = p_wr ? P_SP2 : P_EOL;
            end else err_c = 1'b1;
            P_SP2: if (rx_sh == " ") p_st_nx = P_DHI; else err_c = 1'b1;
            P_DHI: if (hex_c[4]) begin
               p_data_nx[7:4] = hex_c[3:0]; p_st_nx = P_DLO;
            end else err_c = 1'b1;
            P_DLO: if (hex_c[4]) begin
               p_data_nx[3:0] = hex_c[3:0]; p_st_nx = P_EOL;
            end else err_c = 1'b1;
            P_EOL: if (rx_sh == 8'h0A) begin
               p_st_nx = P_IDLE; req_c = 1'b1;
               if (p_wr) begin
                  we_c = (p_addr != 4'hD); req_msg_c = {".\r\n", 8'h00};
               end else begin
                  req_len_c = 3'd4; req_msg_c = {hex_chr(rd_c[7:4]), hex_chr(rd_c[3:0]), "\r\n"};
               end
            end else err_c = 1'b1;
            default: p_st_nx = P_IDLE;
         endcase
         if (err_c) begin p_st_nx = P_IDLE; req_c = 1'b1; end
      end
   end

   // TX sequencer and serializer; a response requested while busy is dropped
   always_comb begin
      banner_pend_nx = banner_pend; msg_act_nx = msg_act; msg_ban_nx = msg_ban;
      msg_idx_nx = msg_idx; msg_len_nx = msg_len; msg_buf_nx = msg_buf;
      tx_st_nx = tx_st; tx_sh_nx = tx_sh; tx_cnt_nx = tx_cnt; tx_bit_nx = tx_bit;
      if (!test_enable) begin
         if (!msg_act && banner_pend) begin
            banner_pend_nx = 1'b0; msg_act_nx = 1'b1; msg_ban_nx = 1'b1;
            msg_len_nx = 4'd13; msg_idx_nx = '0;
         end else if (!msg_act && req_c) begin
            msg_act_nx = 1'b1; msg_ban_nx = 1'b0; msg_len_nx = {1'b0, req_len_c};
            msg_idx_nx = '0; msg_buf_nx = req_msg_c;
         end
         case (tx_st)
            T_IDLE: if (msg_act) begin
               if (msg_idx == msg_len) msg_act_nx = 1'b0;
               else begin
                  tx_sh_nx = {1'b1, (msg_ban ? banner_chr(msg_idx) : msg_buf[31:24]), 1'b0};
                  if (!msg_ban) msg_buf_nx = {msg_buf[23:0], 8'h00};
                  msg_idx_nx = msg_idx + 1'b1; tx_cnt_nx = '0; tx_bit_nx = '0;
                  tx_st_nx = T_SEND;
               end
            end
            T_SEND: if (tx_cnt == CW'(BIT - 1)) begin
               tx_cnt_nx = '0; tx_sh_nx = {1'b1, tx_sh[9:1]}; tx_bit_nx = tx_bit + 1'b1;
               if (tx_bit == 4'd9) tx_st_nx = T_IDLE;
            end else tx_cnt_nx = tx_cnt + 1'b1;
            default: tx_st_nx = T_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < 8; i++) begin : g_gpio
      assign gpio_port_a[i] = (core_rst_n && regs[14][i]) ? regs[15][i] : 1'bz;
   end
endmodule

// File: tb/tb_soc_wrap_core.sv
// Directed bench for soc_wrap_core: banner, poke/peek, GPIO drive/readback, errors, loopback, reset abort.
module tb_soc_wrap_core;
   localparam int unsigned BIT = 8;

   logic clk = 1'b0;
   logic resetn, db_resetn, test_enable, db_rxd;
   logic [7:0] ext_oe, ext_val;
   wire        db_txd;
   wire  [7:0] gpio;
   int n_run = 0, n_fail = 0, lows;
   logic [7:0] rb;
   bit rok;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 8; i++) begin : g_ext
      assign gpio[i] = ext_oe[i] ? ext_val[i] : 1'bz;
   end

   soc_wrap_core #(.CLK_FREQ_MHZ(1), .DEBUG_SERIAL_BAUD(125000)) dut (
      .clk(clk), .resetn(resetn), .db_resetn(db_resetn), .test_enable(test_enable),
      .db_rxd(db_rxd), .db_txd(db_txd), .gpio_port_a(gpio));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         db_rxd = f[i];
         repeat (BIT) @(negedge clk);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic recv_byte(output logic [7:0] b, output bit ok);
      int t;
      t = 0; ok = 1'b1; b = 8'h00;
      while (db_txd !== 1'b0 && t < 4000) begin @(negedge clk); t++; end
      if (t >= 4000) begin ok = 1'b0; return; end
      repeat (BIT / 2) @(negedge clk);
      if (db_txd !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin repeat (BIT) @(negedge clk); b[i] = db_txd; end
      repeat (BIT) @(negedge clk);
      if (db_txd !== 1'b1) ok = 1'b0;
   endtask

   task automatic expect_resp(input string tag, input string r);
      logic [7:0] b;
      bit ok;
      for (int i = 0; i < r.len(); i++) begin
         recv_byte(b, ok);
         check({tag, "_frame"}, 32'(ok), 32'd1);
         check(tag, 32'(b), 32'(r[i]));
      end
   endtask

   task automatic cmd(input string tag, input string c, input string r);
      fork
         send_str(c);
         expect_resp(tag, r);
      join
   endtask

   initial begin
      resetn = 1'b0; db_resetn = 1'b0; test_enable = 1'b0; db_rxd = 1'b1;
      ext_oe = 8'h00; ext_val = 8'h00;
      repeat (10) @(negedge clk);
      check("txd_in_reset", 32'(db_txd), 32'd1);
      db_resetn = 1'b1;
      expect_resp("banner", "DW_Debugger\r\n");

      // core reset still low: pins must float, so the external drive is what reads back
      ext_oe = 8'hFF; ext_val = 8'h33;
      cmd("poke_e", "p E FF\n", ".\r\n");
      cmd("poke_f", "p F 5A\n", ".\r\n");
      cmd("pins_core_rst", "r D\n", "33\r\n");
      ext_oe = 8'h00;
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      check("gpio_5a", 32'(gpio), 32'h5A);
      cmd("peek_e", "r e\n", "FF\r\n");

      cmd("poke_e0f", "p E 0F\n", ".\r\n");
      cmd("poke_fff", "p F FF\n", ".\r\n");
      ext_oe = 8'hF0; ext_val = 8'hA0;
      repeat (4) @(negedge clk);
      check("gpio_low_nibble", 32'(gpio[3:0]), 32'hF);
      cmd("peek_pins", "r D\n", "AF\r\n");
      cmd("poke_d_ignored", "p D 00\n", ".\r\n");
      cmd("peek_pins2", "r D\n", "AF\r\n");
      ext_oe = 8'h00;

      fork
         begin
            send_byte(8'h00); send_str("p 3"); send_byte(8'h00);
            send_str(" c"); send_byte(8'h00); send_str("4\r\n");
         end
         expect_resp("poke3_nul", ".\r\n");
      join
      cmd("peek3", "r 3\n", "C4\r\n");
      cmd("bad_cmd", "x\n", "?\r\n");
      cmd("bad_hex", "p 3G\n", "?\r\n");
      cmd("peek3_kept", "r 3\n", "C4\r\n");

      test_enable = 1'b1;
      repeat (4) @(negedge clk);
      fork
         send_byte(8'h55);
         begin
            recv_byte(rb, rok);
            check("loop_frame", 32'(rok), 32'd1);
            check("loop_byte", 32'(rb), 32'h55);
         end
      join
      repeat (BIT * 2) @(negedge clk);
      test_enable = 1'b0;
      lows = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (db_txd === 1'b0) lows++;
      end
      check("loop_no_response", 32'(lows), 32'd0);
      cmd("peek3_after_loop", "r 3\n", "C4\r\n");

      // debug reset while the peek response is mid-frame
      send_str("r 3\n");
      repeat (BIT * 3) @(negedge clk);
      db_resetn = 1'b0;
      repeat (3) @(negedge clk);
      check("txd_abort", 32'(db_txd), 32'd1);
      db_resetn = 1'b1;
      expect_resp("banner2", "DW_Debugger\r\n");
      cmd("peek3_cleared", "r 3\n", "00\r\n");
      cmd("peek_e_cleared", "r E\n", "00\r\n");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
